// File: rtl/stream_add_tree_if.sv
// Valid/ready bundle for stream_add_tree: NUM_CH joined input channels and one sum output.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface stream_add_tree_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = DATA_W + $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [OUT_W-1:0]         o_data;
    logic                     o_valid;
    logic                     o_ready;
    logic                     o_sat;

    modport master (
        output in_data, in_valid, o_ready,
        input  in_ready, o_data, o_valid, o_sat
    );

    modport slave (
        input  in_data, in_valid, o_ready,
        output in_ready, o_data, o_valid, o_sat
    );
endinterface

// File: rtl/stream_add_tree.sv
// N-channel unsigned stream adder: joins one beat per channel and sums it through a registered
// binary tree, one stage per level. Optional output saturation via STREAM_ADD_TREE_SAT_EN.
module stream_add_tree #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = DATA_W + $clog2(NUM_CH)
) (
    input logic clk,
    input logic rst,
    stream_add_tree_if.slave bus
);
    localparam int L      = $clog2(NUM_CH);
    localparam int LEAVES = 1 << L;
    localparam int SUM_W  = DATA_W + L;

    logic [DATA_W-1:0] leaf [LEAVES];
    logic              all_v;
    logic              accept;
    logic [L:0]        stage_ready;
    logic [L-1:0]      stage_valid;
    logic [SUM_W-1:0]  total;

    // Pad the tree to a power of two with zero leaves so odd channel counts need no special case.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < NUM_CH) begin : g_used
            assign leaf[i] = bus.in_data[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    assign all_v          = &bus.in_valid;
    assign stage_ready[L] = bus.o_ready;
    assign accept         = all_v & stage_ready[0] & ~rst;
    assign bus.in_ready   = {NUM_CH{accept}};

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NODES = LEAVES >> (k + 1);
        localparam int W     = DATA_W + k + 1;

        logic [W-1:0] sum_d [NODES];
        logic [W-1:0] sum_q [NODES];
        logic         valid_q;
        logic         load_v;

        assign stage_ready[k] = ~valid_q | stage_ready[k+1];
        assign stage_valid[k] = valid_q;

        if (k == 0) begin : g_first
            assign load_v = all_v;
            always_comb begin
                for (int j = 0; j < NODES; j++) begin
                    sum_d[j] = W'(leaf[2*j]) + W'(leaf[2*j+1]);
                end
            end
        end else begin : g_next
            assign load_v = stage_valid[k-1];
            always_comb begin
                for (int j = 0; j < NODES; j++) begin
                    sum_d[j] = W'(g_lvl[k-1].sum_q[2*j]) + W'(g_lvl[k-1].sum_q[2*j+1]);
                end
            end
        end

        // Data only loads with a valid beat, so a stalled stage keeps its sum untouched.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                for (int j = 0; j < NODES; j++) begin
                    sum_q[j] <= '0;
                end
            end else if (stage_ready[k]) begin
                valid_q <= load_v;
                if (load_v) begin
                    for (int j = 0; j < NODES; j++) begin
                        sum_q[j] <= sum_d[j];
                    end
                end
            end
        end
    end

    assign total       = g_lvl[L-1].sum_q[0];
    assign bus.o_valid = stage_valid[L-1];

`ifdef STREAM_ADD_TREE_SAT_EN
    if (OUT_W < SUM_W) begin : g_sat
        logic over;
        assign over       = |total[SUM_W-1:OUT_W];
        assign bus.o_data = over ? '1 : total[OUT_W-1:0];
        assign bus.o_sat  = over;
    end else begin : g_full
        assign bus.o_data = OUT_W'(total);
        assign bus.o_sat  = 1'b0;
    end
`else
    if (OUT_W < SUM_W) begin : g_wrap
        logic unused_hi;
        assign unused_hi = ^total[SUM_W-1:OUT_W];
    end
    assign bus.o_data = OUT_W'(total);
    assign bus.o_sat  = 1'b0;
`endif
endmodule

// File: tb/tb_stream_add_tree.sv
// Directed bench for stream_add_tree: 4-channel full width, 4-channel OUT_W=9, and 3-channel instances.
module tb_stream_add_tree;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst9, rst3;

    stream_add_tree_if #(.NUM_CH(4), .DATA_W(8), .OUT_W(10)) if4 ();
    stream_add_tree_if #(.NUM_CH(4), .DATA_W(8), .OUT_W(9))  if9 ();
    stream_add_tree_if #(.NUM_CH(3), .DATA_W(8), .OUT_W(10)) if3 ();

    stream_add_tree #(.NUM_CH(4), .DATA_W(8), .OUT_W(10)) dut4 (.clk(clk), .rst(rst4), .bus(if4));
    stream_add_tree #(.NUM_CH(4), .DATA_W(8), .OUT_W(9))  dut9 (.clk(clk), .rst(rst9), .bus(if9));
    stream_add_tree #(.NUM_CH(3), .DATA_W(8), .OUT_W(10)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];
    int pushed     = 0;
    int popped     = 0;
    int cyc        = 0;
    int first_pop  = -1;
    int last_pop   = -1;
    int pushed_ref = 0;
    logic [7:0] cur [4];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                  input logic [7:0] d, input logic [3:0] v, input logic rdy);
        if4.in_data  = {d, c, b, a};
        if4.in_valid = v;
        if4.o_ready  = rdy;
        #1;
    endtask

    // One scoreboarded cycle on the 4-channel instance; the producer holds a beat until accepted.
    task automatic run_cycle4(input logic [3:0] v, input logic rdy);
        apply_stimulus(cur[0], cur[1], cur[2], cur[3], v, rdy);
        if (if4.o_valid) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_o_valid", 32'(if4.o_valid), 32'd0);
            end else begin
                check_output("stream_sum", 32'(if4.o_data), exp_q[0]);
                check_output("stream_sat", 32'(if4.o_sat), 32'd0);
                if (rdy) begin
                    void'(exp_q.pop_front());
                    popped++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
        if (v == 4'hF && if4.in_ready == 4'hF) begin
            exp_q.push_back(int'(cur[0]) + int'(cur[1]) + int'(cur[2]) + int'(cur[3]));
            pushed++;
            for (int i = 0; i < 4; i++) cur[i] = 8'($urandom_range(0, 255));
        end
        cyc++;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst4 = 1'b1;
        rst9 = 1'b1;
        rst3 = 1'b1;
        if9.in_data = '0; if9.in_valid = '0; if9.o_ready = 1'b1;
        if3.in_data = '0; if3.in_valid = '0; if3.o_ready = 1'b1;
        apply_stimulus(8'd1, 8'd2, 8'd3, 8'd4, 4'hF, 1'b1);

        // Reset held for three cycles with every input valid.
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("rst_in_ready", 32'(if4.in_ready), 32'd0);
            check_output("rst_o_valid", 32'(if4.o_valid), 32'd0);
            check_output("rst_o_data", 32'(if4.o_data), 32'd0);
        end
        rst4 = 1'b0;
        rst9 = 1'b0;
        rst3 = 1'b0;
        #1;
        check_output("first_in_ready", 32'(if4.in_ready), 32'hF);
        check_output("first_o_valid", 32'(if4.o_valid), 32'd0);
        step();
        apply_stimulus(8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b1);
        check_output("lat1_o_valid", 32'(if4.o_valid), 32'd0);
        step();
        check_output("lat2_o_valid", 32'(if4.o_valid), 32'd1);
        check_output("lat2_o_data", 32'(if4.o_data), 32'd10);
        step();
        check_output("after_pop_o_valid", 32'(if4.o_valid), 32'd0);

        // Join: channel 3 missing blocks every channel.
        apply_stimulus(8'd9, 8'd9, 8'd9, 8'd9, 4'b0111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_output("join_in_ready", 32'(if4.in_ready), 32'd0);
            check_output("join_o_valid", 32'(if4.o_valid), 32'd0);
            step();
        end
        apply_stimulus(8'd5, 8'd6, 8'd7, 8'd8, 4'hF, 1'b1);
        check_output("join_all_ready", 32'(if4.in_ready), 32'hF);
        step();
        apply_stimulus(8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b1);
        step();
        check_output("join_o_valid_beat", 32'(if4.o_valid), 32'd1);
        check_output("join_o_data", 32'(if4.o_data), 32'd26);
        step();
        check_output("join_single_beat", 32'(if4.o_valid), 32'd0);

        // Streaming at full rate; the first beat is the maximum 4*255.
        for (int i = 0; i < 4; i++) cur[i] = 8'd255;
        exp_q.delete();
        for (int i = 0; i < 100; i++) run_cycle4(4'hF, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle4(4'h0, 1'b1);
        check_output("stream_pushed", 32'(pushed), 32'd100);
        check_output("stream_popped", 32'(popped), 32'd100);
        check_output("stream_rate", 32'(last_pop - first_pop), 32'd99);

        // Backpressure: capacity is two beats.
        pushed_ref = pushed;
        for (int i = 0; i < 5; i++) run_cycle4(4'hF, 1'b0);
        check_output("bp_accepted", 32'(pushed - pushed_ref), 32'd2);
        apply_stimulus(cur[0], cur[1], cur[2], cur[3], 4'hF, 1'b0);
        check_output("bp_in_ready", 32'(if4.in_ready), 32'd0);
        check_output("bp_o_valid", 32'(if4.o_valid), 32'd1);
        for (int i = 0; i < 200; i++) run_cycle4(4'hF, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) run_cycle4(4'h0, 1'b1);
        check_output("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("bp_no_loss", 32'(popped), 32'(pushed));

        // Width reduction to 9 bits: 1020 either saturates or wraps to 508.
        if9.in_data  = {4{8'hFF}};
        if9.in_valid = 4'hF;
        #1;
        check_output("w9_in_ready", 32'(if9.in_ready), 32'hF);
        step();
        if9.in_valid = 4'h0;
        step();
        check_output("w9_o_valid", 32'(if9.o_valid), 32'd1);
`ifdef STREAM_ADD_TREE_SAT_EN
        check_output("w9_o_data", 32'(if9.o_data), 32'd511);
        check_output("w9_o_sat", 32'(if9.o_sat), 32'd1);
`else
        check_output("w9_o_data", 32'(if9.o_data), 32'd508);
        check_output("w9_o_sat", 32'(if9.o_sat), 32'd0);
`endif

        // Three channels: padded leaf is zero, latency still two cycles.
        if3.in_data  = {8'd9, 8'd8, 8'd7};
        if3.in_valid = 3'b111;
        #1;
        check_output("ch3_in_ready", 32'(if3.in_ready), 32'h7);
        step();
        if3.in_valid = 3'b000;
        #1;
        check_output("ch3_lat1", 32'(if3.o_valid), 32'd0);
        step();
        check_output("ch3_o_valid", 32'(if3.o_valid), 32'd1);
        check_output("ch3_o_data", 32'(if3.o_data), 32'd24);
        step();

        // Reset with two beats in flight discards both.
        if3.in_data  = {8'd3, 8'd2, 8'd1};
        if3.in_valid = 3'b111;
        step();
        if3.in_data  = {8'd6, 8'd5, 8'd4};
        step();
        rst3 = 1'b1;
        #1;
        check_output("ch3_rst_in_ready", 32'(if3.in_ready), 32'd0);
        step();
        check_output("ch3_rst_o_valid", 32'(if3.o_valid), 32'd0);
        rst3 = 1'b0;
        if3.in_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("ch3_no_stale", 32'(if3.o_valid), 32'd0);
        end
        if3.in_data  = {8'd1, 8'd1, 8'd1};
        if3.in_valid = 3'b111;
        #1;
        step();
        if3.in_valid = 3'b000;
        step();
        check_output("ch3_post_rst_valid", 32'(if3.o_valid), 32'd1);
        check_output("ch3_post_rst_data", 32'(if3.o_data), 32'd3);
        step();
        check_output("ch3_post_rst_pop", 32'(if3.o_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
